// File: rtl/regfile_fwd.sv
// regfile_fwd: general-purpose register file for the 5-stage core.
//   It has two combinational read ports and one synchronous WB write port.
//   Read data is forwarded from the EX, MEM and WB stages, and load-use
//   hazards are detected here. Stall cycles are counted by a saturating counter.
//
// Ports:
//   clk, resetn            core clock; asynchronous active-low reset
//   raddr1/rdata1          read port 1 (data is combinational)
//   raddr2/rdata2          read port 2 (data is combinational)
//   we, waddr, wdata       WB write port
//   ex_to_rf_bus           {ex_we, ex_is_load, ex_waddr, ex_result}
//   mem_to_rf_bus          {mem_we, mem_waddr, mem_result}
//   stall_req              load-use hazard; ID holds for one cycle
//   stall_cnt              number of cycles stall_req was high, saturating
//
// Optional feature (macro REGFILE_HILO_EN):
//   Adds HI/LO registers with write-through reads.
//   Ports: hilo_we[1:0] = {hi_we, lo_we}, hi_wdata, lo_wdata, hi_rdata, lo_rdata.
module regfile_fwd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [ADDR_W-1:0]          raddr1,
  output logic [DATA_W-1:0]          rdata1,
  input  logic [ADDR_W-1:0]          raddr2,
  output logic [DATA_W-1:0]          rdata2,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W+ADDR_W+1:0]   ex_to_rf_bus,
  input  logic [DATA_W+ADDR_W:0]     mem_to_rf_bus,
`ifdef REGFILE_HILO_EN
  input  logic [1:0]                 hilo_we,
  input  logic [DATA_W-1:0]          hi_wdata,
  input  logic [DATA_W-1:0]          lo_wdata,
  output logic [DATA_W-1:0]          hi_rdata,
  output logic [DATA_W-1:0]          lo_rdata,
`endif
  output logic                       stall_req,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic                 ex_we, ex_is_load, mem_we;
  logic [ADDR_W-1:0]    ex_waddr, mem_waddr;
  logic [DATA_W-1:0]    ex_result, mem_result;

  assign {ex_we, ex_is_load, ex_waddr, ex_result} = ex_to_rf_bus;
  assign {mem_we, mem_waddr, mem_result}          = mem_to_rf_bus;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign rdata1   = rdata[0];
  assign rdata2   = rdata[1];

  // An EX-stage load has no result yet, so it is never forwarded.
  // The port falls through to MEM/WB/array; stall_req tells ID to re-read.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata[p] = regs[raddr[p]];
      if (raddr[p] == '0)
        rdata[p] = '0;
      else if (ex_we && !ex_is_load && ex_waddr == raddr[p])
        rdata[p] = ex_result;
      else if (mem_we && mem_waddr == raddr[p])
        rdata[p] = mem_result;
      else if (we && waddr == raddr[p])
        rdata[p] = wdata;
    end
  end

  assign stall_req = ex_we && ex_is_load && (ex_waddr != '0) &&
                     ((ex_waddr == raddr1) || (ex_waddr == raddr2));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt <= '0;
    else if (stall_req && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

`ifdef REGFILE_HILO_EN
  logic [DATA_W-1:0] hi_q, lo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hilo_we[1]) hi_q <= hi_wdata;
      if (hilo_we[0]) lo_q <= lo_wdata;
    end
  end

  assign hi_rdata = hilo_we[1] ? hi_wdata : hi_q;
  assign lo_rdata = hilo_we[0] ? lo_wdata : lo_q;
`endif

endmodule

// File: tb/tb_regfile_fwd.sv
module tb_regfile_fwd;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 2 ** CNT_W - 1;

  logic clk = 0;
  logic resetn = 0;
  logic [ADDR_W-1:0] raddr1 = 0, raddr2 = 0, waddr = 0, ex_waddr = 0, mem_waddr = 0;
  logic [DATA_W-1:0] wdata = 0, ex_result = 0, mem_result = 0;
  logic we = 0, ex_we = 0, ex_is_load = 0, mem_we = 0;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic stall_req;
  logic [CNT_W-1:0] stall_cnt;
  logic [DATA_W+ADDR_W+1:0] ex_to_rf_bus;
  logic [DATA_W+ADDR_W:0]   mem_to_rf_bus;

  assign ex_to_rf_bus  = {ex_we, ex_is_load, ex_waddr, ex_result};
  assign mem_to_rf_bus = {mem_we, mem_waddr, mem_result};

`ifdef REGFILE_HILO_EN
  logic [1:0] hilo_we = 0;
  logic [DATA_W-1:0] hi_wdata = 0, lo_wdata = 0;
  logic [DATA_W-1:0] hi_rdata, lo_rdata;
  logic [DATA_W-1:0] hi_m = 0, lo_m = 0;
`endif

  regfile_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .raddr1(raddr1), .rdata1(rdata1),
    .raddr2(raddr2), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .ex_to_rf_bus(ex_to_rf_bus), .mem_to_rf_bus(mem_to_rf_bus),
`ifdef REGFILE_HILO_EN
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
`endif
    .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 0;

  // Reference model: plain array plus an integer stall count.
  logic [DATA_W-1:0] m_regs [32];
  int m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return 0;
    if (ex_we && !ex_is_load && ex_waddr == a) return ex_result;
    if (mem_we && mem_waddr == a) return mem_result;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic bit exp_stall();
    return ex_we && ex_is_load && ex_waddr != 0 && (ex_waddr == raddr1 || ex_waddr == raddr2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_cnt = 0;
`ifdef REGFILE_HILO_EN
    hi_m = 0; lo_m = 0;
`endif
  endtask

  initial model_clear();
  always @(negedge resetn) model_clear();

  always @(posedge clk) begin
    if (resetn) begin
      if (exp_stall() && m_cnt < CNT_MAX) m_cnt++;
      if (we && waddr != 0) m_regs[waddr] = wdata;
`ifdef REGFILE_HILO_EN
      if (hilo_we[1]) hi_m = hi_wdata;
      if (hilo_we[0]) lo_m = lo_wdata;
`endif
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("rdata1", rdata1, exp_read(raddr1));
      check("rdata2", rdata2, exp_read(raddr2));
      check("stall_req", stall_req, exp_stall());
      check("stall_cnt", stall_cnt, m_cnt);
`ifdef REGFILE_HILO_EN
      check("hi_rdata", hi_rdata, hilo_we[1] ? hi_wdata : hi_m);
      check("lo_rdata", lo_rdata, hilo_we[0] ? lo_wdata : lo_m);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; ex_we = 0; ex_is_load = 0; mem_we = 0;
`ifdef REGFILE_HILO_EN
    hilo_we = 0;
`endif
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, 31));
    return ADDR_W'($urandom_range(0, 7));
  endfunction

  initial begin
    // Reset and read all addresses with idle buses.
    resetn = 0;
    step(); step();
    resetn = 1;
    checking = 1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = ADDR_W'(i); raddr2 = ADDR_W'(31 - i);
      #1;
      check("reset_rd1", rdata1, 0);
      check("reset_rd2", rdata2, 0);
    end
    check("reset_cnt", stall_cnt, 0);

    // WB write, then read it back; a write to reg 0 is discarded.
    step(); we = 1; waddr = 5; wdata = 32'h1234_5678;
    step(); we = 0; raddr1 = 5;
    #1 check("wb_read5", rdata1, 32'h1234_5678);
    step(); we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
    step(); we = 0; raddr1 = 0; raddr2 = 0;
    #1 check("reg0_read", rdata1, 0);

    // Forwarding priority.
    step(); we = 1; waddr = 7; wdata = 1;
    step();
    mem_we = 1; mem_waddr = 7; mem_result = 2;
    ex_we = 1; ex_is_load = 0; ex_waddr = 7; ex_result = 3;
    we = 1; waddr = 7; wdata = 4;
    raddr1 = 7; raddr2 = 7;
    #1 check("prio_ex1", rdata1, 3);
    check("prio_ex2", rdata2, 3);
    ex_we = 0;
    #1 check("prio_mem1", rdata1, 2);
    check("prio_mem2", rdata2, 2);
    mem_we = 0;
    #1 check("prio_wb1", rdata1, 4);
    check("prio_wb2", rdata2, 4);

    // Load-use stall.
    step(); idle(); raddr1 = 0; raddr2 = 9;
    ex_we = 1; ex_is_load = 1; ex_waddr = 9; ex_result = 32'hDEAD;
    #1 check("lu_stall", stall_req, 1);
    check("lu_not_dead", rdata2 != 32'hDEAD, 1);
    check("lu_cnt0", stall_cnt, 0);
    step(); ex_waddr = 0;
    #1 check("lu_r0_nostall", stall_req, 0);
    check("lu_cnt1", stall_cnt, 1);

    // Saturation of the stall counter.
    ex_waddr = 3; raddr1 = 3;
    for (int i = 0; i < 2 ** CNT_W + 5; i++) step();
    check("cnt_sat", stall_cnt, CNT_MAX);
    idle();

`ifdef REGFILE_HILO_EN
    step(); hilo_we = 2'b11; hi_wdata = 32'h11; lo_wdata = 32'h22;
    step(); hilo_we = 2'b10; hi_wdata = 32'hA5;
    #1 check("hi_wt", hi_rdata, 32'hA5);
    check("lo_keep", lo_rdata, 32'h22);
    step(); hilo_we = 2'b11; hi_wdata = 32'h77; lo_wdata = 32'h88;
    #1 resetn = 0;
    step(); hilo_we = 0;
    #1 check("hi_rst", hi_rdata, 0);
    check("lo_rst", lo_rdata, 0);
    resetn = 1;
`endif

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        resetn = 0;
        #2;
        check("midrst_cnt", stall_cnt, 0);
        step();
        resetn = 1;
      end
      raddr1 = rnd_addr(); raddr2 = rnd_addr();
      we = $urandom_range(0, 1); waddr = rnd_addr(); wdata = $urandom;
      ex_we = ($urandom_range(0, 2) != 0); ex_is_load = ($urandom_range(0, 3) == 0);
      ex_waddr = rnd_addr(); ex_result = $urandom;
      mem_we = $urandom_range(0, 1); mem_waddr = rnd_addr(); mem_result = $urandom;
`ifdef REGFILE_HILO_EN
      hilo_we = 2'($urandom_range(0, 3)); hi_wdata = $urandom; lo_wdata = $urandom;
`endif
    end
    step();
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
